// File: rtl/vga_plot_receiver.sv
// Plot-interface receiver: range-checks plots, converts (x, y) to a linear framebuffer
// address, queues {addr, colour} in a FIFO and drains it into a stallable write port.
module vga_plot_receiver #(
  parameter int DEPTH = 8,
  parameter int H_RES = 320,
  parameter int V_RES = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  vga_x,
  input  logic [7:0]  vga_y,
  input  logic [2:0]  vga_colour,
  input  logic        vga_plot,
  output logic        ready,
  output logic [16:0] fb_addr,
  output logic [2:0]  fb_data,
  output logic        fb_we,
  input  logic        fb_stall,
  output logic [7:0]  drop_count,
  output logic        overflow,
  output logic        idle
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [9:0]    H_LIM = 10'(H_RES);
  localparam logic [8:0]    V_LIM = 9'(V_RES);

  logic [19:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_drop_count;
  logic          r_overflow;
  logic [16:0]   r_last_addr;
  logic [2:0]    r_last_data;

  logic [16:0] w_addr;
  logic        w_in_range;
  logic        w_ready;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic [19:0] w_head;

  generate
    if (H_RES == 320) begin : g_addr_shift
      // 320 = 256 + 64, so the multiply collapses to two shifted adds.
      assign w_addr = ({9'b0, vga_y} << 8) + ({9'b0, vga_y} << 6) + {8'b0, vga_x};
    end else begin : g_addr_mult
      assign w_addr = 17'((32'(vga_y) * H_RES) + 32'(vga_x));
    end
  endgenerate

  assign w_in_range = ({1'b0, vga_x} < H_LIM) && ({1'b0, vga_y} < V_LIM);
  assign w_ready    = (r_count < FULL);
  assign w_empty    = (r_count == '0);
  assign w_push     = vga_plot && w_in_range && w_ready;
  assign w_pop      = !w_empty && !fb_stall;
  assign w_head     = r_mem[r_rd_ptr];

  // Storage has no reset: reads are only exposed while the entry is valid.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= {w_addr, vga_colour};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
      r_last_addr  <= '0;
      r_last_data  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_last_addr <= w_head[19:3];
        r_last_data <= w_head[2:0];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (vga_plot && !w_in_range && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 1'b1;
      end
      if (vga_plot && w_in_range && !w_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // When empty, the port keeps showing the last written entry so it never glitches.
  assign fb_we      = !w_empty;
  assign fb_addr    = w_empty ? r_last_addr : w_head[19:3];
  assign fb_data    = w_empty ? r_last_data : w_head[2:0];
  assign ready      = w_ready;
  assign idle       = w_empty;
  assign drop_count = r_drop_count;
  assign overflow   = r_overflow;

endmodule
